// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory with a valid/ready request
// handshake, fixed access latency and an out-of-range error flag.
// Ports: clk/reset (async, active-high); req_valid_i/req_ready_o with
//   req_we_i, req_addr_i (word address) and req_wdata_i; resp_valid_o/resp_ready_i
//   with resp_rdata_o and resp_err_o; busy_o is high outside IDLE.
// Latency: resp_valid_o rises LATENCY edges after the accepting edge.
// Backpressure: the response is held until resp_ready_i; there is one request in flight.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [31:0]           req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  busy_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be in 1..15");
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 31) begin : g_bad_addr_width
    $error("data_mem_responder: ADDR_WIDTH must be in 1..31");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 state_q;
  logic [3:0]             cnt_q;
  logic [31:0]            addr_q;
  logic                   we_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  logic                   req_ready_q;
  logic                   resp_valid_q;
  logic [DATA_WIDTH-1:0]  resp_rdata_q;
  logic                   resp_err_q;
  logic                   busy_q;

  // Any set bit above the implemented range is an error, so high addresses
  // never alias onto low words.
  logic                   addr_oor;
  logic [ADDR_WIDTH-1:0]  word_idx;

  assign addr_oor = |addr_q[31:ADDR_WIDTH];
  assign word_idx = addr_q[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            addr_q      <= req_addr_i;
            we_q        <= req_we_i;
            wdata_q     <= req_wdata_i;
            cnt_q       <= 4'(LATENCY - 1);
            state_q     <= S_WAIT;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            // Commit edge: the array is touched only here, so a reset while
            // waiting drops the access entirely.
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            if (addr_oor) begin
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (we_q) begin
              mem_q[word_idx] <= wdata_q;
              resp_err_q      <= 1'b0;
              resp_rdata_q    <= '0;
            end else begin
              resp_err_q   <= 1'b0;
              resp_rdata_q <= mem_q[word_idx];
            end
          end
        end
        S_RESP: begin
          // req_ready stays low on the completing edge; the next request is
          // taken one edge later from IDLE.
          if (resp_ready_i) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: instance a uses LATENCY=2 with driven
// resp_ready; instance b uses LATENCY=1 with resp_ready tied high.
// Expected responses are queued when a request is accepted and popped when
// the response appears.
module tb_data_mem_responder;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          cyc = 0;
  int          tests_run = 0;
  int          fails = 0;

  // instance a (LATENCY=2)
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        busy_o;

  // instance b (LATENCY=1)
  logic        b_req_valid = 1'b0;
  logic        b_req_ready;
  logic        b_req_we = 1'b0;
  logic [31:0] b_req_addr = '0;
  logic [31:0] b_req_wdata = '0;
  logic        b_resp_valid;
  logic        b_resp_ready = 1'b1;
  logic [31:0] b_resp_rdata;
  logic        b_resp_err;
  logic        b_busy;

  exp_t exp_q[$];
  exp_t b_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(2)) u_dut_a (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o), .busy_o(busy_o)
  );

  data_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(1)) u_dut_b (
    .clk(clk), .reset(reset),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
    .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
    .resp_valid_o(b_resp_valid), .resp_ready_i(b_resp_ready),
    .resp_rdata_o(b_resp_rdata), .resp_err_o(b_resp_err), .busy_o(b_busy)
  );

  // Stimulus: called at a negedge; presents a request once req_ready is high,
  // returns at the negedge after the accepting edge with that edge's cyc value.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, output int acc_cyc);
    int n = 0;
    while (!req_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    exp_q.push_back('{err: exp_err, rdata: exp_rdata});
    @(negedge clk);
    acc_cyc     = cyc;
    req_valid_i = 1'b0;
  endtask

  // Stimulus: waits (bounded) at negedges for resp_valid on instance a.
  task automatic wait_valid(output int resp_cyc, output bit ok);
    int n = 0;
    while (!resp_valid_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok       = resp_valid_o;
    resp_cyc = cyc;
  endtask

  // Stimulus: completes the pending response on instance a in one edge.
  task automatic complete_resp();
    resp_ready_i = 1'b1;
    @(negedge clk);
    resp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    int acc, rc;
    bit ok;
    exp_t e;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(1'b0, 32'h05, 32'h0, 32'h0, 1'b0, acc);
    tests_run++;
    if (busy_o !== 1'b1) begin fails++; $display("FAIL rst_busy_before act=%b req=1", busy_o); end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || busy_o !== 1'b0 ||
        resp_rdata_o !== 32'h0 || resp_err_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_async act rdy=%b vld=%b busy=%b rdata=%h err=%b req rdy=1 vld=0 busy=0 rdata=0 err=0",
               req_ready_o, resp_valid_o, busy_o, resp_rdata_o, resp_err_o);
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(1'b0, 32'h05, 32'h0, 32'h0, 1'b0, acc);
    wait_valid(rc, ok);
    tests_run++;
    if (!ok) begin fails++; $display("FAIL rst_read_timeout act=no_resp req=resp"); end
    e = exp_q.pop_front();
    tests_run++;
    if (resp_rdata_o !== e.rdata || resp_err_o !== e.err) begin
      fails++;
      $display("FAIL rst_read_05 act=%h/%b req=%h/%b", resp_rdata_o, resp_err_o, e.rdata, e.err);
    end
    complete_resp();
  endtask

  task automatic test_write_read();
    int acc0, acc1, rc;
    bit ok;
    exp_t e;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, acc0);
    wait_valid(rc, ok);
    tests_run++;
    if (!ok || rc - acc0 !== 2) begin
      fails++; $display("FAIL wr_latency act=%0d req=2 (valid=%b)", rc - acc0, ok);
    end
    e = exp_q.pop_front();
    tests_run++;
    if (resp_rdata_o !== e.rdata || resp_err_o !== e.err) begin
      fails++; $display("FAIL wr_resp act=%h/%b req=%h/%b", resp_rdata_o, resp_err_o, e.rdata, e.err);
    end
    complete_resp();
    issue(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, acc1);
    tests_run++;
    if (acc1 - acc0 !== 4) begin fails++; $display("FAIL wr_rd_spacing act=%0d req=4", acc1 - acc0); end
    wait_valid(rc, ok);
    tests_run++;
    if (!ok || rc - acc1 !== 2) begin
      fails++; $display("FAIL rd_latency act=%0d req=2 (valid=%b)", rc - acc1, ok);
    end
    e = exp_q.pop_front();
    tests_run++;
    if (resp_rdata_o !== e.rdata || resp_err_o !== e.err) begin
      fails++; $display("FAIL rd_after_wr act=%h/%b req=%h/%b", resp_rdata_o, resp_err_o, e.rdata, e.err);
    end
    complete_resp();
  endtask

  task automatic test_backpressure();
    int acc, rc;
    bit ok;
    exp_t e;
    issue(1'b1, 32'h30, 32'h12345678, 32'h0, 1'b0, acc);
    wait_valid(rc, ok);
    void'(exp_q.pop_front());
    complete_resp();
    issue(1'b0, 32'h30, 32'h0, 32'h12345678, 1'b0, acc);
    wait_valid(rc, ok);
    tests_run++;
    if (!ok) begin fails++; $display("FAIL bp_timeout act=no_resp req=resp"); end
    e = exp_q.pop_front();
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_addr_i  = 32'h31;
    req_wdata_i = 32'hBAD0BAD0;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (resp_valid_o !== 1'b1 || resp_rdata_o !== e.rdata || resp_err_o !== e.err ||
          req_ready_o !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d] act vld=%b rdata=%h err=%b rdy=%b req vld=1 rdata=%h err=%b rdy=0",
                 i, resp_valid_o, resp_rdata_o, resp_err_o, req_ready_o, e.rdata, e.err);
      end
      @(negedge clk);
    end
    req_valid_i = 1'b0;
    complete_resp();
    tests_run++;
    if (resp_valid_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL bp_release act vld=%b busy=%b rdy=%b req vld=0 busy=0 rdy=1",
               resp_valid_o, busy_o, req_ready_o);
    end
    // the stray write to 0x31 must not have happened
    issue(1'b0, 32'h31, 32'h0, 32'h0, 1'b0, acc);
    wait_valid(rc, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || resp_rdata_o !== e.rdata) begin
      fails++; $display("FAIL bp_stray_write act=%h req=%h", resp_rdata_o, e.rdata);
    end
    complete_resp();
  endtask

  task automatic test_out_of_range();
    int acc, rc;
    bit ok;
    exp_t e;
    issue(1'b1, 32'h00000100, 32'hFFFFFFFF, 32'h0, 1'b1, acc);
    wait_valid(rc, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || resp_rdata_o !== e.rdata || resp_err_o !== e.err) begin
      fails++; $display("FAIL oor_write act=%h/%b req=%h/%b", resp_rdata_o, resp_err_o, e.rdata, e.err);
    end
    complete_resp();
    issue(1'b0, 32'h00, 32'h0, 32'h0, 1'b0, acc);
    wait_valid(rc, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || resp_rdata_o !== e.rdata || resp_err_o !== e.err) begin
      fails++; $display("FAIL oor_alias act=%h/%b req=%h/%b", resp_rdata_o, resp_err_o, e.rdata, e.err);
    end
    complete_resp();
    issue(1'b0, 32'h80000010, 32'h0, 32'h0, 1'b1, acc);
    wait_valid(rc, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || resp_rdata_o !== e.rdata || resp_err_o !== e.err) begin
      fails++; $display("FAIL oor_read_hi act=%h/%b req=%h/%b", resp_rdata_o, resp_err_o, e.rdata, e.err);
    end
    complete_resp();
  endtask

  task automatic test_reset_wait();
    int acc, rc;
    bit ok;
    exp_t e;
    bit seen;
    issue(1'b1, 32'h20, 32'hAAAA5555, 32'h0, 1'b0, acc);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid_o !== 1'b0) seen = 1'b1;
    end
    tests_run++;
    if (seen || busy_o !== 1'b0) begin
      fails++; $display("FAIL rstwait_no_resp act vld_seen=%b busy=%b req 0/0", seen, busy_o);
    end
    reset = 1'b0;
    @(negedge clk);
    issue(1'b0, 32'h20, 32'h0, 32'h0, 1'b0, acc);
    wait_valid(rc, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || resp_rdata_o !== e.rdata || resp_err_o !== e.err) begin
      fails++; $display("FAIL rstwait_read act=%h/%b req=%h/%b", resp_rdata_o, resp_err_o, e.rdata, e.err);
    end
    complete_resp();
  endtask

  task automatic test_back_to_back();
    int acc, prev, n;
    exp_t e;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!b_req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      b_req_valid = 1'b1;
      b_req_we    = (i < 2);
      b_req_addr  = (i % 2 == 0) ? 32'h01 : 32'h02;
      b_req_wdata = (i % 2 == 0) ? 32'h11111111 : 32'h22222222;
      b_q.push_back('{err: 1'b0, rdata: (i < 2) ? 32'h0 : b_req_wdata});
      @(negedge clk);
      acc         = cyc;
      b_req_valid = 1'b0;
      if (i > 0) begin
        tests_run++;
        if (acc - prev !== 3) begin fails++; $display("FAIL b2b_spacing[%0d] act=%0d req=3", i, acc - prev); end
      end
      prev = acc;
      n = 0;
      while (!b_resp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      e = b_q.pop_front();
      tests_run++;
      if (b_resp_valid !== 1'b1 || cyc - acc !== 1 || b_resp_rdata !== e.rdata || b_resp_err !== e.err) begin
        fails++;
        $display("FAIL b2b_resp[%0d] act lat=%0d rdata=%h err=%b req lat=1 rdata=%h err=%b",
                 i, cyc - acc, b_resp_rdata, b_resp_err, e.rdata, e.err);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_out_of_range();
    test_reset_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Word-addressed data memory that serves as the responder for the processor's data-memory port (address, write data, read/write strobes).
- Adds a valid/ready request handshake, a configurable access latency and an out-of-range error flag, so the multicycle core can be stalled on slow memory.
- Sits between the core's address/data-in muxes and its MEM-stage data register, replacing the zero-wait memory.

Parameters:
- ADDR_WIDTH, 8, number of implemented word-address bits; depth is 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, word width in bits.
- LATENCY, 2, clock edges from request acceptance to resp_valid; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  32  word address.
- req_wdata  input  DATA_WIDTH  write data.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors.
- resp_err  output  1  address out of range.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous: state goes to IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0. The wait counter and all memory words are cleared to 0.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - A rising edge with req_valid=1 accepts the request. Address, we and wdata are captured into internal registers, cnt is loaded with LATENCY-1, and the FSM moves to WAIT.
  - Request inputs are not sampled after acceptance.
- WAIT:
  - req_ready=0.
  - Each edge with cnt!=0 decrements cnt.
  - The edge with cnt==0 commits the access and moves to RESP with resp_valid=1.
  - resp_valid therefore rises exactly LATENCY edges after the accepting edge.
- Commit:
  - Range check: captured addr[31:ADDR_WIDTH] nonzero means resp_err=1, no array access, resp_rdata=0.
  - In-range write: mem[addr[ADDR_WIDTH-1:0]] <= wdata; resp_rdata=0; resp_err=0.
  - In-range read: resp_rdata <= mem[addr]; resp_err=0.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until an edge with resp_ready=1.
  - That edge returns the FSM to IDLE and clears resp_valid, resp_rdata and resp_err.
  - req_ready stays 0 in RESP, so no request is accepted on the response-completing edge.
  - Minimum spacing between acceptances is therefore LATENCY+2 edges (LATENCY edges to the response, one edge to complete it, one edge in IDLE to accept).
- Read-after-write to the same address returns the new data; the write is committed before the next request can be accepted.
- Reset mid-operation in WAIT: the pending write is not committed and no response is produced. Reset in RESP discards the response; a write already committed stays committed until the array clear (the reset clears the array anyway).
- req_valid toggling while req_ready=0 has no effect.
- resp_ready asserted outside RESP is ignored.
- The LATENCY range is checked at elaboration; out-of-range values are an error.

Test Plan:
- Reset then idle: assert reset mid-cycle -> req_ready=1, resp_valid=0, busy=0 immediately (async). A read of addr 0x05 after release returns 0x00000000.
- Write then read, LATENCY=2:
  - Write addr 0x10 data 0xDEADBEEF accepted at edge t0 -> resp_valid=1 after edge t2, resp_err=0, rdata=0.
  - With resp_ready=1 at t3 the FSM returns to IDLE; a read of 0x10 accepted at t4 -> resp_rdata=0xDEADBEEF after t6.
- Backpressure: hold resp_ready=0 for 5 cycles during a read of a word holding 0x12345678 -> resp_valid, rdata and err stay constant; req_valid=1 is not accepted (req_ready=0). Releasing resp_ready completes in one edge.
- Out of range, ADDR_WIDTH=8: write to 0x00000100 with 0xFFFFFFFF -> resp_err=1, rdata=0; a subsequent read of 0x00 returns 0 (no aliasing).
- Reset during WAIT: write 0xAAAA5555 to 0x20, assert reset one edge after acceptance -> no resp_valid; a later read of 0x20 returns 0.
- LATENCY=1 back-to-back: reads of 0x01, 0x02 with resp_ready tied 1 -> each resp_valid exactly 1 edge after acceptance; acceptances spaced 3 edges apart.
